// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage read-after-write hazard detector. A shift-register
//               scoreboard records the destination register of each in-flight
//               instruction downstream of ID (slot 0 = EXE, slot 1 = MEM, ...).
//               The decoding instruction's sources are checked against it, and
//               hazard_detected tells decode to hold ID and bubble into EXE.
//               Stall cycles are counted in a saturating counter for
//               performance debug.
//
// Build option: FORWARDING_EN
//               defined   -> EXE/MEM forwarding exists; only a load sitting in
//                            slot 0 whose result is needed causes a stall.
//               undefined -> any matching producer in any slot stalls.
//
// Ports       : clk              clock, all state on the rising edge
//               rst              synchronous active-high reset
//               id_valid         ID holds a real instruction
//               id_src1/id_src2  decoding instruction sources
//               id_single_src    1: id_src2 is not a real operand
//               id_dest          decoding instruction destination
//               id_wb_en         decoding instruction writes the register file
//               id_mem_r_en      decoding instruction is a load
//               flush            taken branch squashes the ID instruction
//               freeze           whole pipe holds (memory/multicycle stall)
//               hazard_detected  ID must hold, bubble into EXE (combinational)
//               stall_count      saturating count of hazard stall cycles
//
// Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_single_src,
    input  logic [4:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             flush,
    input  logic             freeze,
    output logic             hazard_detected,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Scoreboard slots, index 0 is the youngest (EXE)
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0][4:0] r_dest;
    logic [DEPTH-1:0]      r_wb_en;
    logic [DEPTH-1:0]      r_mem_r_en;
    logic [CNT_W-1:0]      r_stall_count;

    logic [DEPTH-1:0]      w_match1;
    logic [DEPTH-1:0]      w_match2;
    logic                  w_raw_hazard;
    logic                  w_hazard;
    logic                  w_bubble;
    logic                  w_unused_last_slot;

    // Register 0 is hard-wired, so a write to it never creates a dependency
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign w_match1[gi] = r_valid[gi] & r_wb_en[gi] &
                              (r_dest[gi] == id_src1) & (id_src1 != 5'd0);
        assign w_match2[gi] = r_valid[gi] & r_wb_en[gi] &
                              (r_dest[gi] == id_src2) & (id_src2 != 5'd0);
    end

`ifdef FORWARDING_EN
    // Forwarding covers everything except a load result still in EXE
    assign w_raw_hazard = (w_match1[0] | (~id_single_src & w_match2[0])) & r_mem_r_en[0];
`else
    assign w_raw_hazard = (|w_match1) | (~id_single_src & (|w_match2));
`endif

    // A flushed or empty ID stage never stalls; flush therefore wins over a
    // hazard and that cycle is not counted as a stall.
    assign w_hazard        = id_valid & ~flush & w_raw_hazard;
    assign hazard_detected = w_hazard;
    assign stall_count     = r_stall_count;

    assign w_bubble = w_hazard | flush | ~id_valid;

    // The oldest slot only feeds the compare (or nothing, with forwarding);
    // it retires after that.
    assign w_unused_last_slot = ^{r_valid[DEPTH-1], r_dest[DEPTH-1],
                                  r_wb_en[DEPTH-1], r_mem_r_en[DEPTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_dest        <= '0;
            r_wb_en       <= '0;
            r_mem_r_en    <= '0;
            r_stall_count <= '0;
        end else if (!freeze) begin
            if (w_bubble) begin
                r_valid[0]    <= 1'b0;
                r_dest[0]     <= 5'd0;
                r_wb_en[0]    <= 1'b0;
                r_mem_r_en[0] <= 1'b0;
            end else begin
                r_valid[0]    <= 1'b1;
                r_dest[0]     <= id_dest;
                r_wb_en[0]    <= id_wb_en;
                r_mem_r_en[0] <= id_mem_r_en;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i]    <= r_valid[i-1];
                r_dest[i]     <= r_dest[i-1];
                r_wb_en[i]    <= r_wb_en[i-1];
                r_mem_r_en[i] <= r_mem_r_en[i-1];
            end
            if (w_hazard && (r_stall_count != c_cnt_max)) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Randomised plus directed bench for hazard_scoreboard. A driver
//               pushes expected responses from an age-ordered list of
//               in-flight producers; a monitor compares on every falling edge.
//               A second instance with a 3-bit counter exposes saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_src1 = '0;
    logic [4:0]  id_src2 = '0;
    logic        id_single_src = 1'b0;
    logic [4:0]  id_dest = '0;
    logic        id_wb_en = 1'b0;
    logic        id_mem_r_en = 1'b0;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;
    logic        hz_a, hz_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_single_src(id_single_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .freeze(freeze), .hazard_detected(hz_a), .stall_count(cnt_a)
    );

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_single_src(id_single_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .freeze(freeze), .hazard_detected(hz_b), .stall_count(cnt_b)
    );

    typedef struct packed {
        bit       v;
        bit [4:0] s1;
        bit [4:0] s2;
        bit       ss;
        bit [4:0] d;
        bit       wb;
        bit       ld;
    } instr_t;

    typedef struct {
        bit        hz;
        bit [15:0] c16;
        bit [2:0]  c3;
        int        ph;
    } exp_t;

    exp_t        expq[$];
    instr_t      inflight[$];   // index 0 = most recently issued
    int unsigned total_stalls = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          phase = 0;
    bit          last_h = 1'b0;

    function automatic instr_t mk(bit v, bit [4:0] s1, bit [4:0] s2, bit ss,
                                  bit [4:0] d, bit wb, bit ld);
        instr_t x;
        x.v = v; x.s1 = s1; x.s2 = s2; x.ss = ss; x.d = d; x.wb = wb; x.ld = ld;
        return x;
    endfunction

    function automatic bit writes(instr_t p, bit [4:0] r);
        return p.v && p.wb && (p.d == r) && (r != 5'd0);
    endfunction

    function automatic bit model_hazard(instr_t i, bit fl);
        bit h;
        bit dep;
        h = 1'b0;
        if (!i.v || fl) return 1'b0;
        for (int a = 0; a < inflight.size(); a++) begin
            dep = writes(inflight[a], i.s1) || (!i.ss && writes(inflight[a], i.s2));
`ifdef FORWARDING_EN
            if (a == 0 && inflight[a].ld && dep) h = 1'b1;
`else
            if (dep) h = 1'b1;
`endif
        end
        return h;
    endfunction

    function automatic bit [15:0] sat16(int unsigned t);
        int unsigned m;
        m = (t > 65535) ? 65535 : t;
        return m[15:0];
    endfunction

    function automatic bit [2:0] sat3(int unsigned t);
        int unsigned m;
        m = (t > 7) ? 7 : t;
        return m[2:0];
    endfunction

    task automatic clear_model();
        inflight.delete();
        for (int k = 0; k < DEPTH; k++) inflight.push_back('0);
        total_stalls = 0;
    endtask

    // One clock of stimulus: drive, push expectation, advance the model
    task automatic step(input bit r, input instr_t ins, input bit fl, input bit fz);
        exp_t e;
        bit   h;
        @(posedge clk);
        #1;
        rst = r; id_valid = ins.v; id_src1 = ins.s1; id_src2 = ins.s2;
        id_single_src = ins.ss; id_dest = ins.d; id_wb_en = ins.wb;
        id_mem_r_en = ins.ld; flush = fl; freeze = fz;
        h = model_hazard(ins, fl);
        e.hz = h; e.c16 = sat16(total_stalls); e.c3 = sat3(total_stalls); e.ph = phase;
        expq.push_back(e);
        last_h = h;
        if (r) begin
            clear_model();
        end else if (!fz) begin
            if (h) total_stalls++;
            inflight.push_front((h || fl || !ins.v) ? instr_t'('0) : ins);
            void'(inflight.pop_back());
        end
    endtask

    // Present an instruction until it leaves ID (bounded)
    task automatic issue(input instr_t ins);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, ins, 1'b0, 1'b0);
            if (!last_h) break;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented output against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                vectors++;
                if (hz_a !== e.hz) begin
                    miscompares++;
                    $display("FAIL hazard ph=%0d vec=%0d got=%b exp=%b", e.ph, vectors, hz_a, e.hz);
                end
                if (hz_b !== e.hz) begin
                    miscompares++;
                    $display("FAIL hazard_small ph=%0d vec=%0d got=%b exp=%b", e.ph, vectors, hz_b, e.hz);
                end
                if (cnt_a !== e.c16) begin
                    miscompares++;
                    $display("FAIL stall_count ph=%0d vec=%0d got=%h exp=%h", e.ph, vectors, cnt_a, e.c16);
                end
                if (cnt_b !== e.c3) begin
                    miscompares++;
                    $display("FAIL stall_count_sat ph=%0d vec=%0d got=%h exp=%h", e.ph, vectors, cnt_b, e.c3);
                end
            end
        end
    end

    initial begin
        instr_t cur;
        bit     r, fl, fz;
        clear_model();

        // Reset held, then idle: nothing in flight, count zero
        phase = 1;
        repeat (2) @(posedge clk);
        step(1'b1, '0, 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, mk(1, 5'd3, 5'd4, 0, 5'd6, 1, 0), 1'b0, 1'b0);

        // ALU producer followed by a src1 reader
        phase = 2;
        idle(2);
        issue(mk(1, 5'd1, 5'd2, 0, 5'd3, 1, 0));
        issue(mk(1, 5'd3, 5'd0, 1, 5'd9, 1, 0));
        idle(2);

        // Load-use through src2, then a single-source reader of the same reg
        phase = 3;
        issue(mk(1, 5'd1, 5'd0, 1, 5'd5, 1, 1));
        issue(mk(1, 5'd1, 5'd5, 0, 5'd10, 1, 0));
        idle(2);
        issue(mk(1, 5'd1, 5'd0, 1, 5'd5, 1, 1));
        issue(mk(1, 5'd1, 5'd5, 1, 5'd11, 1, 0));
        idle(2);

        // Writes to r0 never create hazards
        phase = 4;
        issue(mk(1, 5'd1, 5'd2, 0, 5'd0, 1, 1));
        issue(mk(1, 5'd0, 5'd0, 0, 5'd12, 1, 0));
        idle(2);

        // Freeze holds a pending hazard; flush with a hazard inserts a bubble
        phase = 5;
        issue(mk(1, 5'd1, 5'd2, 0, 5'd7, 1, 1));
        cur = mk(1, 5'd7, 5'd7, 0, 5'd13, 1, 0);
        step(1'b0, cur, 1'b0, 1'b1);
        step(1'b0, cur, 1'b0, 1'b1);
        step(1'b0, cur, 1'b0, 1'b1);
        issue(cur);
        idle(2);
        issue(mk(1, 5'd1, 5'd2, 0, 5'd8, 1, 1));
        step(1'b0, mk(1, 5'd8, 5'd0, 1, 5'd14, 1, 0), 1'b1, 1'b0);
        idle(3);

        // Drive the small counter into saturation, then reset mid-stall
        phase = 6;
        for (int k = 0; k < 10; k++) begin
            issue(mk(1, 5'd1, 5'd2, 0, 5'd9, 1, 1));
            issue(mk(1, 5'd9, 5'd9, 0, 5'd15, 1, 0));
        end
        idle(1);
        issue(mk(1, 5'd1, 5'd2, 0, 5'd4, 1, 1));
        cur = mk(1, 5'd4, 5'd0, 1, 5'd16, 1, 0);
        step(1'b0, cur, 1'b0, 1'b0);
        step(1'b1, cur, 1'b0, 1'b0);
        step(1'b0, cur, 1'b0, 1'b0);
        idle(2);

        // Random traffic on a small register window to provoke dependencies
        phase = 7;
        cur = '0;
        for (int n = 0; n < 600; n++) begin
            if (!(last_h && ($urandom_range(0, 3) != 0))) begin
                cur.v  = ($urandom_range(0, 7) != 0);
                cur.s1 = 5'($urandom_range(0, 3));
                cur.s2 = 5'($urandom_range(0, 3));
                cur.ss = $urandom_range(0, 1) == 1;
                cur.d  = 5'($urandom_range(0, 3));
                cur.wb = ($urandom_range(0, 4) != 0);
                cur.ld = $urandom_range(0, 1) == 1;
            end
            r  = ($urandom_range(0, 63) == 0);
            fl = ($urandom_range(0, 9) == 0);
            fz = ($urandom_range(0, 7) == 0);
            step(r, cur, fl, fz);
        end
        idle(1);

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
